// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: shared FSM states, multiplier latency and index-width helper for mult_arbiter
package mult_arb_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, CAPTURE} arb_state_e;
   localparam int MULT_LATENCY = 2;
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/mult_arb_grant.sv
// mult_arb_grant: one-hot grant plus index; round-robin with MULT_ARB_RR_EN, else fixed priority
module mult_arb_grant
   import mult_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IW = idx_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
`ifdef MULT_ARB_RR_EN
   input  logic [IW-1:0]      ptr,
`endif
   output logic [NUM_REQ-1:0] gnt,
   output logic [IW-1:0]      idx
);
   always_comb begin
      gnt = '0;
      idx = '0;
`ifdef MULT_ARB_RR_EN
      // walk offsets from farthest to nearest so ptr+1 is written last and wins
      for (int i = NUM_REQ; i >= 1; i--) begin
         if (req[(int'(ptr) + i) % NUM_REQ]) begin
            gnt = '0;
            gnt[(int'(ptr) + i) % NUM_REQ] = 1'b1;
            idx = IW'((int'(ptr) + i) % NUM_REQ);
         end
      end
`else
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            gnt = '0;
            gnt[i] = 1'b1;
            idx = IW'(i);
         end
      end
`endif
   end
endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter: shares one two-cycle multiplier among NUM_REQ requesters.
// Define MULT_ARB_RR_EN for round-robin arbitration; fixed priority otherwise.
module mult_arbiter
   import mult_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int IN_WIDTH  = 4,
   parameter int OUT_WIDTH = 2 * IN_WIDTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ*IN_WIDTH-1:0]  req_a,
   input  logic [NUM_REQ*IN_WIDTH-1:0]  req_b,
   output logic [NUM_REQ-1:0]           req_ready,
   output logic [NUM_REQ-1:0]           rsp_valid,
   output logic [OUT_WIDTH-1:0]         rsp_data,
   output logic [IN_WIDTH-1:0]          m_multiplicand,
   output logic [IN_WIDTH-1:0]          m_multiplier,
   output logic                         m_enable,
   input  logic [OUT_WIDTH-1:0]         m_result,
   input  logic                         m_done
);
   localparam int IW = idx_w(NUM_REQ);
   arb_state_e state_q, state_d;
   logic [IN_WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [IW-1:0] tag_q, tag_d, gnt_idx;
   logic [NUM_REQ-1:0] gnt, rsp_valid_q, rsp_valid_d;
   logic [OUT_WIDTH-1:0] rsp_data_q, rsp_data_d;
   // m_done stays high after the first product, so sequencing relies on the FSM alone
   logic unused_done;
   assign unused_done = m_done;
`ifdef MULT_ARB_RR_EN
   logic [IW-1:0] ptr_q, ptr_d;
`endif
   mult_arb_grant #(.NUM_REQ(NUM_REQ), .IW(IW)) u_grant (
      .req (req_valid),
`ifdef MULT_ARB_RR_EN
      .ptr (ptr_q),
`endif
      .gnt (gnt),
      .idx (gnt_idx)
   );
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      tag_d       = tag_q;
      rsp_valid_d = '0;
      rsp_data_d  = rsp_data_q;
`ifdef MULT_ARB_RR_EN
      ptr_d       = ptr_q;
`endif
      unique case (state_q)
         IDLE: if (|req_valid) begin
            a_d     = req_a[gnt_idx*IN_WIDTH +: IN_WIDTH];
            b_d     = req_b[gnt_idx*IN_WIDTH +: IN_WIDTH];
            tag_d   = gnt_idx;
            state_d = LOAD;
`ifdef MULT_ARB_RR_EN
            ptr_d   = gnt_idx;
`endif
         end
         LOAD:    state_d = COMPUTE;
         COMPUTE: state_d = CAPTURE;
         CAPTURE: begin
            rsp_data_d  = m_result;
            rsp_valid_d = NUM_REQ'(1) << tag_q;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         tag_q       <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
`ifdef MULT_ARB_RR_EN
         ptr_q       <= IW'(NUM_REQ - 1);
`endif
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         tag_q       <= tag_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
`ifdef MULT_ARB_RR_EN
         ptr_q       <= ptr_d;
`endif
      end
   end
   assign req_ready      = (state_q == IDLE) ? gnt : '0;
   assign m_enable       = (state_q == LOAD) || (state_q == COMPUTE);
   assign m_multiplicand = a_q;
   assign m_multiplier   = b_q;
   assign rsp_valid      = rsp_valid_q;
   assign rsp_data       = rsp_data_q;
endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Shares one sequential multiplier datapath (two-cycle enable/done core, `IN_WIDTH`-bit operands, `OUT_WIDTH`-bit product) between `NUM_REQ` requesters, such as PRNG lanes needing LCG multiplies. It arbitrates requests, latches the winner's operands, sequences the multiplier's enable over its fixed latency, and returns the product to the granted requester. It sits between the requester lanes and the single multiplier instance.

## Interface
- `NUM_REQ`, default 4: number of requesters, ≥2.
- `IN_WIDTH`, default 4: operand width.
- `OUT_WIDTH`, default `2*IN_WIDTH`: product width.
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high. The same signal resets the shared multiplier.
- `req_valid`, in, `NUM_REQ`: per-requester request. Held until accepted.
- `req_a`, in, `NUM_REQ*IN_WIDTH`: multiplicands. Lane i is `[i*IN_WIDTH +: IN_WIDTH]`.
- `req_b`, in, `NUM_REQ*IN_WIDTH`: multipliers, same packing as `req_a`.
- `req_ready`, out, `NUM_REQ`: one-hot, single-cycle accept pulse.
- `rsp_valid`, out, `NUM_REQ`: one-hot, single-cycle result pulse.
- `rsp_data`, out, `OUT_WIDTH`: product. Valid while any `rsp_valid` bit is high.
- `m_multiplicand`, out, `IN_WIDTH`: to multiplier.
- `m_multiplier`, out, `IN_WIDTH`: to multiplier.
- `m_enable`, out, 1: multiplier enable.
- `m_result`, in, `OUT_WIDTH`: multiplier product.
- `m_done`, in, 1: multiplier done. This is sticky after the first operation, so it is not used for sequencing.

## Operation
- FSM states:
  - IDLE: accepts a request.
  - LOAD: multiplier samples the operands.
  - COMPUTE: multiplier forms the product.
  - CAPTURE: product is read.
- IDLE:
  - If any `req_valid` is set, grant one lane g.
  - Pulse `req_ready[g]`, latch `req_a`/`req_b` lane g into operand registers, latch g as the tag, go to LOAD.
  - Otherwise stay in IDLE.
- LOAD: `m_enable`=1, latched operands on `m_multiplicand`/`m_multiplier`, go to COMPUTE.
- COMPUTE: `m_enable`=1, go to CAPTURE.
- CAPTURE:
  - `m_enable`=0.
  - Register `rsp_data` <= `m_result` and `rsp_valid` <= onehot(tag).
  - Go to IDLE.
- `m_enable` is 0 in IDLE and CAPTURE. It must never be high for more than two consecutive cycles.
- Operands stay constant from LOAD through CAPTURE. Changes on `req_*` after acceptance have no effect.
- The product is taken unmodified from the multiplier. No truncation when `OUT_WIDTH` = `2*IN_WIDTH`.
- Requests from non-granted lanes stay pending. No request is ever dropped.
- Response path has no backpressure. Requesters must accept `rsp_valid` the cycle it is high.

## Timing
- Reset values:
  - `req_ready`, `rsp_valid`, `rsp_data`, `m_enable`, `m_multiplicand`, `m_multiplier` = 0.
  - FSM = IDLE; round-robin pointer = `NUM_REQ-1`, so lane 0 has top priority first.
- Latency: accept at edge T → `rsp_valid` high in cycle T+4.
- A new accept can occur in that same cycle T+4. Sustained throughput is one product per 4 cycles.
- `req_ready` is combinationally decoded from the IDLE state and registered request inputs are not required. It is high only in IDLE.
- `rst` mid-operation:
  - Abort immediately and return to reset values. The in-flight result is discarded and no `rsp_valid` is issued.
  - The requester must re-request.
- Arrival on the same cycle as a response (cycle T+4): the request is eligible and accepted that cycle.

## Configuration
- `MULT_ARB_RR_EN` defined: round-robin.
  - Search starts at pointer+1, modulo `NUM_REQ`, wrapping.
  - Pointer updates to g only on accept.
- Not defined: fixed priority. Lowest asserted index wins and no pointer exists.

## Structure
- `mult_arb_pkg` holds:
  - FSM state enum: IDLE, LOAD, COMPUTE, CAPTURE.
  - `MULT_LATENCY` = 2.
  - Index-width helper (clog2 of `NUM_REQ`).
- Sub-module `mult_arb_grant`: pure grant logic (request vector + pointer → one-hot grant + index). Both arbitration modes live inside it under the macro.
- The multiplier is instantiated by the parent, not inside this block.

## Test plan
- Single request: lane 2 requests a=15, b=15. `req_ready[2]` pulses at T; `rsp_valid[2]` at T+4 with `rsp_data`=225; `m_enable` high exactly 2 cycles.
- All four lanes request continuously with `RR_EN`. Grants go 0,1,2,3,0, each 4 cycles apart, and each `rsp_data` equals that lane's a×b.
- Same stimulus without `RR_EN`. Lane 0 wins every accept while its `req_valid` is held.
- Operand hold: lane 1 has a=3, b=5 accepted, then its inputs change to 7/7 during LOAD. Response is 15.
- Reset in COMPUTE: `rst` for one cycle. No `rsp_valid`, all outputs 0. A re-request of 2×6 afterwards returns 12.
- Back-to-back: a lane 3 request arrives in lane 0's CAPTURE cycle. It is accepted the next cycle, with the response 4 cycles later.
